rom_dl_ctrl: RTL and testbench
==============================

ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 16, meaning clk_sys cycles core_reset stays high after a download ends.
REQ-002 SHALL have parameter EXP_BYTES, default 20512 (0x5020), meaning minimum byte count for an error-free download.
REQ-003 SHALL have port clk_sys  in  1  system clock; all state on its rising edge.
REQ-004 SHALL have port I_RESET_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port dn_download  in  1  HPS download active level.
REQ-006 SHALL have port dn_addr  in  16  download byte address.
REQ-007 SHALL have port dn_data  in  8  download byte.
REQ-008 SHALL have port dn_wr  in  1  download write strobe; level, may stay high more than one cycle.
REQ-009 SHALL have port sw_reset  in  1  OSD/button reset request.
REQ-010 SHALL have port core_reset  out  1  reset to the game core, active-high.
REQ-011 SHALL have port cpu_we / gfx_we / prom_we  out  1 each  one-cycle region write strobes.
REQ-012 SHALL have port wr_addr  out  14  region-relative write address.
REQ-013 SHALL have port wr_data  out  8  write data.
REQ-014 SHALL have port dl_busy  out  1  high in LOAD state.
REQ-015 SHALL have port dl_error  out  1  sticky short-download flag.
REQ-016 SHALL have port byte_count  out  17  accepted writes in current or last download.

Function
REQ-017 SHALL implement states IDLE, LOAD, HOLD, RUN.
REQ-018 SHALL transition IDLE->LOAD, and RUN->LOAD, on a dn_download rising edge, detected with a registered copy of dn_download.
REQ-019 SHALL transition LOAD->HOLD on a dn_download falling edge.
REQ-020 SHALL, in HOLD, count HOLD_CYC cycles, then go to RUN.
REQ-021 SHALL, in RUN, go to HOLD and restart the count when sw_reset=1; in HOLD, restart the count whenever sw_reset=1.
REQ-022 SHALL register core_reset high in IDLE, LOAD and HOLD, and low only in RUN; first low cycle is the cycle after the HOLD count expires.
REQ-023 SHALL accept a write only in LOAD, once per dn_wr rising edge; dn_wr held high SHALL give exactly one write.
REQ-024 SHALL assert the accepted write's strobe in the cycle after the dn_wr edge is sampled, for exactly one cycle, with wr_addr/wr_data registered alongside.
REQ-025 SHALL decode the region from dn_addr: 0x0000-0x3FFF -> cpu_we, wr_addr=dn_addr[13:0].
REQ-026 SHALL decode 0x4000-0x4FFF -> gfx_we, wr_addr={2'b0,dn_addr[11:0]}.
REQ-027 SHALL decode 0x5000-0x501F -> prom_we, wr_addr={9'b0,dn_addr[4:0]}.
REQ-028 SHALL treat addresses >= 0x5020 as no strobe, but still count them.
REQ-029 SHALL never assert more than one of cpu_we/gfx_we/prom_we in a cycle.
REQ-030 SHALL clear byte_count and dl_error on LOAD entry.
REQ-031 SHALL increment byte_count on each accepted write, saturating at 0x1FFFF.
REQ-032 SHALL still accept and count a dn_wr edge sampled in the same cycle as the dn_download falling edge.
REQ-033 SHALL, on LOAD exit, set dl_error=1 if the final count (including REQ-032) < EXP_BYTES; dl_error holds until next LOAD entry.
REQ-034 SHALL ignore dn_wr in IDLE, HOLD and RUN, with no strobe and no count.
REQ-035 SHALL ignore sw_reset in IDLE and LOAD.

Reset
REQ-036 SHALL, on I_RESET_N=0, immediately enter IDLE with core_reset=1, all strobes=0, wr_addr=0, wr_data=0, dl_busy=0, dl_error=0, byte_count=0, hold counter=0, edge registers=0.
REQ-037 SHALL, when reset asserts mid-LOAD, discard any pending strobe and require a fresh dn_download rising edge to leave IDLE.

Verification
REQ-038 Full load: 0x5020 writes at addresses 0..0x501F, then dn_download falls -> 16384 cpu_we, 4096 gfx_we, 32 prom_we; byte_count=0x5020; dl_error=0; core_reset falls 16 cycles after HOLD entry.
REQ-039 Short load: 0x100 writes, then end -> dl_error=1 and byte_count=0x100; core_reset still releases after HOLD.
REQ-040 dn_wr held high 5 cycles at addr 0x4005, data 0xA5 -> single gfx_we one cycle later, wr_addr=0x0005, wr_data=0xA5, byte_count+1.
REQ-041 sw_reset pulse in RUN -> core_reset=1 next cycle for 16 cycles, then 0; dl_error and byte_count unchanged.
REQ-042 I_RESET_N low mid-LOAD, then high with dn_download still 1 -> stays IDLE, no strobes, core_reset=1, until dn_download toggles 0->1.
REQ-043 Write to 0x6000 -> no strobe, byte_count increments.

Source files
------------

// File: rtl/rom_dl_ctrl.sv
// ROM download controller: accepts HPS download bytes, steers each one to the
// CPU, GFX or PROM region as a single-cycle write strobe, counts accepted bytes,
// flags short downloads and holds the game core in reset around a download.
//
// Ports:
//   clk_sys      system clock, all state on its rising edge
//   I_RESET_N    asynchronous active-low reset
//   dn_download  download active level
//   dn_addr      download byte address (16 bits)
//   dn_data      download byte
//   dn_wr        download write strobe (level, one write per rising edge)
//   sw_reset     OSD/button reset request
//   core_reset   active-high reset to the game core
//   cpu_we       one-cycle write strobe, region 0x0000-0x3FFF
//   gfx_we       one-cycle write strobe, region 0x4000-0x4FFF
//   prom_we      one-cycle write strobe, region 0x5000-0x501F
//   wr_addr      region-relative write address (14 bits)
//   wr_data      write data
//   dl_busy      high while in LOAD
//   dl_error     sticky short-download flag
//   byte_count   accepted writes in the current or last download (17 bits)
module rom_dl_ctrl #(
  parameter int unsigned HOLD_CYC  = 16,
  parameter int unsigned EXP_BYTES = 20512
) (
  input  logic        clk_sys,
  input  logic        I_RESET_N,
  input  logic        dn_download,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        dn_wr,
  input  logic        sw_reset,
  output logic        core_reset,
  output logic        cpu_we,
  output logic        gfx_we,
  output logic        prom_we,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        dl_busy,
  output logic        dl_error,
  output logic [16:0] byte_count
);

  localparam int unsigned CNT_W = 17;
  localparam int unsigned HCW   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } state_e;

  state_e             state_q;
  logic [HCW-1:0]     hold_cnt_q;
  logic               dl_q;
  logic               wr_q;
  logic               arm_q;
  logic               core_reset_q;
  logic               cpu_we_q;
  logic               gfx_we_q;
  logic               prom_we_q;
  logic [13:0]        wr_addr_q;
  logic [7:0]         wr_data_q;
  logic               dl_busy_q;
  logic               dl_error_q;
  logic [CNT_W-1:0]   byte_count_q;

  logic               dl_rise_c;
  logic               dl_fall_c;
  logic               wr_rise_c;
  logic               accept_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [CNT_W-1:0]   cnt_new_c;
  logic               short_c;
  logic               hold_done_c;
  logic               reg_cpu_c;
  logic               reg_gfx_c;
  logic               reg_prom_c;
  logic [13:0]        addr_c;

  // arm_q blocks a "rise" right after reset while dn_download is already high:
  // a download must be seen low before a new one can start.
  assign dl_rise_c   = dn_download & ~dl_q & arm_q;
  assign dl_fall_c   = ~dn_download & dl_q;
  assign wr_rise_c   = dn_wr & ~wr_q;
  assign accept_c    = (state_q == ST_LOAD) & wr_rise_c;
  assign cnt_inc_c   = (byte_count_q == '1) ? byte_count_q : byte_count_q + CNT_W'(1);
  // Final count includes a write sampled together with the download falling edge.
  assign cnt_new_c   = accept_c ? cnt_inc_c : byte_count_q;
  assign short_c     = 32'(cnt_new_c) < EXP_BYTES;
  assign hold_done_c = (32'(hold_cnt_q) + 32'd1) >= HOLD_CYC;

  // Region decode and region-relative address.
  always_comb begin
    reg_cpu_c  = 1'b0;
    reg_gfx_c  = 1'b0;
    reg_prom_c = 1'b0;
    addr_c     = dn_addr[13:0];
    if (dn_addr[15:14] == 2'b00) begin
      reg_cpu_c = 1'b1;
    end else if (dn_addr[15:12] == 4'h4) begin
      reg_gfx_c = 1'b1;
      addr_c    = {2'b00, dn_addr[11:0]};
    end else if (dn_addr[15:5] == 11'h280) begin
      reg_prom_c = 1'b1;
      addr_c     = {9'b0, dn_addr[4:0]};
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_sys or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      dl_q         <= 1'b0;
      wr_q         <= 1'b0;
      arm_q        <= 1'b0;
      core_reset_q <= 1'b1;
      cpu_we_q     <= 1'b0;
      gfx_we_q     <= 1'b0;
      prom_we_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      dl_busy_q    <= 1'b0;
      dl_error_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      dl_q      <= dn_download;
      wr_q      <= dn_wr;
      cpu_we_q  <= 1'b0;
      gfx_we_q  <= 1'b0;
      prom_we_q <= 1'b0;
      if (!dn_download) begin
        arm_q <= 1'b1;
      end

      if (accept_c) begin
        cpu_we_q     <= reg_cpu_c;
        gfx_we_q     <= reg_gfx_c;
        prom_we_q    <= reg_prom_c;
        wr_addr_q    <= addr_c;
        wr_data_q    <= dn_data;
        byte_count_q <= cnt_inc_c;
      end

      case (state_q)
        ST_IDLE: begin
          if (dl_rise_c) begin
            state_q      <= ST_LOAD;
            dl_busy_q    <= 1'b1;
            byte_count_q <= '0;
            dl_error_q   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (dl_fall_c) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            dl_busy_q  <= 1'b0;
            dl_error_q <= short_c;
          end
        end
        ST_HOLD: begin
          if (sw_reset) begin
            hold_cnt_q <= '0;
          end else if (hold_done_c) begin
            state_q      <= ST_RUN;
            hold_cnt_q   <= '0;
            core_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HCW'(1);
          end
        end
        ST_RUN: begin
          if (dl_rise_c) begin
            state_q      <= ST_LOAD;
            core_reset_q <= 1'b1;
            dl_busy_q    <= 1'b1;
            byte_count_q <= '0;
            dl_error_q   <= 1'b0;
          end else if (sw_reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            core_reset_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_reset = core_reset_q;
  assign cpu_we     = cpu_we_q;
  assign gfx_we     = gfx_we_q;
  assign prom_we    = prom_we_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign dl_busy    = dl_busy_q;
  assign dl_error   = dl_error_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Bench for rom_dl_ctrl: decode vector table, directed multi-cycle sequences
// and a randomized run, all checked against a behavioural model.
module tb_rom_dl_ctrl;

  localparam int HOLD = 16;
  localparam int EXP  = 20512;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_HOLD = 2;
  localparam int M_RUN  = 3;

  logic        clk_sys;
  logic        I_RESET_N;
  logic        dn_download;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        sw_reset;
  logic        core_reset;
  logic        cpu_we;
  logic        gfx_we;
  logic        prom_we;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        dl_busy;
  logic        dl_error;
  logic [16:0] byte_count;

  rom_dl_ctrl #(.HOLD_CYC(HOLD), .EXP_BYTES(EXP)) dut (
    .clk_sys     (clk_sys),
    .I_RESET_N   (I_RESET_N),
    .dn_download (dn_download),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_wr       (dn_wr),
    .sw_reset    (sw_reset),
    .core_reset  (core_reset),
    .cpu_we      (cpu_we),
    .gfx_we      (gfx_we),
    .prom_we     (prom_we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .dl_busy     (dl_busy),
    .dl_error    (dl_error),
    .byte_count  (byte_count)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int n_cpu  = 0;
  int n_gfx  = 0;
  int n_prom = 0;

  // Behavioural model state.
  int          m_mode;
  bit          m_dl, m_wr, m_armed;
  int          m_hold_left;
  int          m_count;
  bit          m_err;
  bit          m_cpu, m_gfx, m_prom;
  logic [13:0] m_addr;
  logic [7:0]  m_data;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          hold;
    logic [2:0]  exp_we;
    logic [13:0] exp_addr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_dl = 0; m_wr = 0; m_armed = 0; m_hold_left = 0;
    m_count = 0; m_err = 0; m_cpu = 0; m_gfx = 0; m_prom = 0;
    m_addr = '0; m_data = '0;
  endtask

  // Model reaction to one clock edge with the current inputs.
  task automatic model_edge();
    bit rise, fall, wedge;
    rise  = dn_download && !m_dl && m_armed;
    fall  = !dn_download && m_dl;
    wedge = dn_wr && !m_wr;
    m_cpu = 0; m_gfx = 0; m_prom = 0;
    if (m_mode == M_LOAD && wedge) begin
      if (dn_addr < 16'h4000) begin
        m_cpu = 1; m_addr = dn_addr[13:0];
      end else if (dn_addr < 16'h5000) begin
        m_gfx = 1; m_addr = 14'(dn_addr - 16'h4000);
      end else if (dn_addr < 16'h5020) begin
        m_prom = 1; m_addr = 14'(dn_addr - 16'h5000);
      end
      m_data = dn_data;
      if (m_count < 'h1FFFF) m_count++;
    end
    case (m_mode)
      M_IDLE: if (rise) begin m_mode = M_LOAD; m_count = 0; m_err = 0; end
      M_LOAD: if (fall) begin m_err = (m_count < EXP); m_mode = M_HOLD; m_hold_left = HOLD; end
      M_HOLD: begin
        if (sw_reset) m_hold_left = HOLD;
        else begin
          m_hold_left--;
          if (m_hold_left <= 0) m_mode = M_RUN;
        end
      end
      default: begin
        if (rise) begin m_mode = M_LOAD; m_count = 0; m_err = 0; end
        else if (sw_reset) begin m_mode = M_HOLD; m_hold_left = HOLD; end
      end
    endcase
    m_dl = dn_download;
    m_wr = dn_wr;
    if (!dn_download) m_armed = 1;
  endtask

  // One clock: advance model, wait for edge, sample #1 later and compare.
  task automatic step();
    logic [31:0] act, exp;
    model_edge();
    @(posedge clk_sys);
    #1;
    act = {9'b0, core_reset, dl_busy, dl_error, cpu_we, gfx_we, prom_we, byte_count};
    exp = {9'b0, (m_mode != M_RUN), (m_mode == M_LOAD), m_err, m_cpu, m_gfx, m_prom, 17'(m_count)};
    chk("cycle", act, exp);
    if (m_cpu || m_gfx || m_prom)
      chk("wr_bus", {10'b0, wr_addr, wr_data}, {10'b0, m_addr, m_data});
    n_cpu  += int'(cpu_we);
    n_gfx  += int'(gfx_we);
    n_prom += int'(prom_we);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    dn_addr = a; dn_data = d; dn_wr = 1'b1;
    step();
    dn_wr = 1'b0;
    step();
  endtask

  // Counts cycles from HOLD entry until core_reset is first seen low.
  task automatic measure_hold(input string name);
    int n;
    n = 0;
    while (core_reset !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'(HOLD));
  endtask

  task automatic start_load();
    dn_download = 1'b0;
    step();
    dn_download = 1'b1;
    step();
    chk("load_entry_busy", {31'b0, dl_busy}, 32'd1);
    chk("load_entry_clear", {14'b0, dl_error, byte_count}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sw_n, strobes;
    vecs[0]  = '{16'h0000, 8'h11, 1, 3'b100, 14'h0000};
    vecs[1]  = '{16'h3FFF, 8'h22, 1, 3'b100, 14'h3FFF};
    vecs[2]  = '{16'h1234, 8'h33, 2, 3'b100, 14'h1234};
    vecs[3]  = '{16'h4000, 8'h44, 1, 3'b010, 14'h0000};
    vecs[4]  = '{16'h4005, 8'hA5, 5, 3'b010, 14'h0005};
    vecs[5]  = '{16'h4FFF, 8'h55, 1, 3'b010, 14'h0FFF};
    vecs[6]  = '{16'h5000, 8'h66, 1, 3'b001, 14'h0000};
    vecs[7]  = '{16'h501F, 8'h77, 3, 3'b001, 14'h001F};
    vecs[8]  = '{16'h5020, 8'h88, 1, 3'b000, 14'h0000};
    vecs[9]  = '{16'h6000, 8'h99, 1, 3'b000, 14'h0000};
    vecs[10] = '{16'hFFFF, 8'hAA, 1, 3'b000, 14'h0000};

    I_RESET_N = 1'b0; dn_download = 1'b0; dn_addr = '0; dn_data = '0;
    dn_wr = 1'b0; sw_reset = 1'b0;
    model_reset();
    #13;
    chk("reset_outputs",
        {4'b0, core_reset, cpu_we, gfx_we, prom_we, dl_busy, dl_error, wr_addr, wr_data},
        {4'b0, 1'b1, 27'b0});
    chk("reset_count", {15'b0, byte_count}, 32'd0);
    #4 I_RESET_N = 1'b1;

    // IDLE: dn_wr and sw_reset are ignored.
    for (int i = 0; i < 6; i++) begin
      dn_wr = 1'(i % 2); sw_reset = 1'(i == 3);
      step();
    end
    sw_reset = 1'b0; dn_wr = 1'b0;
    chk("idle_ignore", {14'b0, core_reset, dl_busy, byte_count}, {14'b0, 1'b1, 1'b0, 17'd0});

    // Short load: 0x100 CPU writes.
    start_load();
    for (int i = 0; i < 256; i++) do_write(16'(i), 8'(i ^ 8'h3C));
    dn_download = 1'b0;
    step();
    chk("short_error", {31'b0, dl_error}, 32'd1);
    chk("short_count", {15'b0, byte_count}, 32'h100);
    measure_hold("short_hold_len");
    for (int i = 0; i < 4; i++) do_write(16'h0010, 8'h01);
    chk("run_ignore_wr", {15'b0, byte_count}, 32'h100);

    // Region decode vector table.
    start_load();
    for (int k = 0; k < 11; k++) begin
      dn_addr = vecs[k].addr; dn_data = vecs[k].data; dn_wr = 1'b1;
      step();
      chk("vec_we", {29'b0, cpu_we, gfx_we, prom_we}, {29'b0, vecs[k].exp_we});
      if (vecs[k].exp_we != 3'b000) begin
        chk("vec_addr", {18'b0, wr_addr}, {18'b0, vecs[k].exp_addr});
        chk("vec_data", {24'b0, wr_data}, {24'b0, vecs[k].data});
      end
      chk("vec_count", {15'b0, byte_count}, 32'(k + 1));
      strobes = 0;
      for (int h = 1; h < vecs[k].hold; h++) begin
        step();
        strobes += int'(cpu_we) + int'(gfx_we) + int'(prom_we);
      end
      chk("vec_single", 32'(strobes), 32'd0);
      dn_wr = 1'b0;
      step();
    end
    dn_download = 1'b0;
    step();
    chk("vec_load_error", {31'b0, dl_error}, 32'd1);
    measure_hold("vec_hold_len");

    // Full load; the last write coincides with the download falling edge.
    start_load();
    n_cpu = 0; n_gfx = 0; n_prom = 0;
    for (int i = 0; i < 'h5020; i++) begin
      dn_addr = 16'(i); dn_data = 8'(i * 7); dn_wr = 1'b1;
      if (i == 'h501F) dn_download = 1'b0;
      step();
      dn_wr = 1'b0;
      if (i != 'h501F) step();
    end
    chk("full_count", {15'b0, byte_count}, 32'h5020);
    chk("full_error", {31'b0, dl_error}, 32'd0);
    chk("full_cpu_we", 32'(n_cpu), 32'd16384);
    chk("full_gfx_we", 32'(n_gfx), 32'd4096);
    chk("full_prom_we", 32'(n_prom), 32'd32);
    measure_hold("full_hold_len");

    // sw_reset pulse in RUN.
    sw_reset = 1'b1;
    step();
    sw_reset = 1'b0;
    chk("sw_assert", {31'b0, core_reset}, 32'd1);
    sw_n = 1;
    while (core_reset === 1'b1 && sw_n < 64) begin
      step();
      if (core_reset === 1'b1) sw_n++;
    end
    chk("sw_hold_len", 32'(sw_n), 32'(HOLD));
    chk("sw_keeps_stat", {14'b0, dl_error, byte_count}, {14'b0, 1'b0, 17'h5020});

    // Reset asserted mid-LOAD with a strobe pending.
    start_load();
    dn_addr = 16'h0010; dn_data = 8'h5A; dn_wr = 1'b1;
    step();
    chk("midload_strobe", {31'b0, cpu_we}, 32'd1);
    I_RESET_N = 1'b0;
    model_reset();
    #1;
    chk("midload_reset",
        {13'b0, cpu_we, gfx_we, prom_we, core_reset, dl_busy, byte_count},
        {13'b0, 3'b000, 1'b1, 1'b0, 17'd0});
    #2 I_RESET_N = 1'b1;
    n_cpu = 0; n_gfx = 0; n_prom = 0;
    for (int i = 0; i < 10; i++) begin
      dn_wr = 1'(i % 2);
      step();
    end
    dn_wr = 1'b0;
    chk("stay_idle",
        {14'b0, core_reset, dl_busy, byte_count},
        {14'b0, 1'b1, 1'b0, 17'd0});
    chk("stay_idle_strobes", 32'(n_cpu + n_gfx + n_prom), 32'd0);
    start_load();

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) dn_download = ~dn_download;
      dn_wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: dn_addr = 16'($urandom_range(0, 16'h3FFF));
        1: dn_addr = 16'h4000 + 16'($urandom_range(0, 16'h0FFF));
        2: dn_addr = 16'h4FF8 + 16'($urandom_range(0, 47));
        default: dn_addr = 16'($urandom);
      endcase
      dn_data  = 8'($urandom);
      sw_reset = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
